fp_mul: RTL and testbench
=========================

Name: fp_mul

Overview:
- Sequential fixed-point multiplier. It is the inverse companion of the team's fixed-point divider.
- It multiplies an unsigned fixed-point factor (WIDTH bits, FRACTION_WIDTH fractional bits) by an unsigned integer and returns an unsigned integer product.
- The product is rounded or truncated, and saturates on overflow.
- Autotune datapath uses: rescaling sample counts and periods by divider-produced ratios, and reconstructing integers from quotients.
- Handshake, latency model and busy/err semantics match the divider, so the two blocks are interchangeable in stage control.

Parameters:
- WIDTH, 42, total bits of the fixed-point factor.
- FRACTION_WIDTH, 10, fractional bits of the factor. Integer operand/result width INT_WIDTH = WIDTH-FRACTION_WIDTH (32).
- NUM_STAGES, 8, total cycles from accept to result. Includes 1 input-register stage and 1 output-register stage; minimum 3.
- ROUND, 1, 1 = round half up at the fraction boundary; 0 = truncate.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous, active-high reset.
- factor_in  input  WIDTH  unsigned fixed-point multiplier.
- multiplicand_in  input  INT_WIDTH  unsigned integer multiplicand.
- valid_in  input  1  request strobe.
- product_out  output  INT_WIDTH  result, held until next result.
- valid_out  output  1  one-cycle result strobe.
- err_out  output  1  overflow flag, qualified by valid_out.
- busy  output  1  high while an operation is in flight.

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_in is synchronous and active-high.
- Reset values: product_out=0, valid_out=0, err_out=0, busy=0. Internal accumulator, counter and operand registers are all cleared.
- Accept: start = valid_in && !busy. On start at edge k:
  - register both operands;
  - busy<=1, counter<=1;
  - accumulator<=0.
- Ignored requests: valid_in while busy is dropped, not queued. No error is raised.
- Working stages: NUM_WORKING = NUM_STAGES-2 cycles.
  - BITS_PER_STAGE = ceil(WIDTH/NUM_WORKING), which is 7 at defaults.
  - Each cycle consumes the next BITS_PER_STAGE factor bits, LSB first.
  - For each consumed bit, conditionally add the shifted multiplicand into a WIDTH+INT_WIDTH-bit accumulator.
  - The last stage uses only the remaining bits when WIDTH is not a multiple of BITS_PER_STAGE.
- Finish, on the final working cycle:
  - raw = acc + (ROUND ? 2^(FRACTION_WIDTH-1) : 0);
  - res = raw >> FRACTION_WIDTH;
  - overflow = any bit of res above INT_WIDTH-1 is set.
  - Output register loads product_out = overflow ? all ones : res[INT_WIDTH-1:0], and err_out = overflow.
- Output timing:
  - valid_out is high for exactly the one cycle following edge k+NUM_STAGES-1.
  - busy stays high through that cycle and clears at edge k+NUM_STAGES.
  - The next accept is possible at edge k+NUM_STAGES.
- Held outputs: product_out and err_out hold their values after valid_out drops.
- Zero operands: a factor or multiplicand of 0 gives product 0 and err 0, with the normal latency. There is no early exit.
- Reset mid-operation: the operation is aborted. busy=0 and valid_out=0 from the next cycle, and no result is produced.
- Reset priority: reset has priority over start in the same cycle.

Decomposition:
- Shared package fp_pkg:
  - FP_WIDTH=42, FP_FRACTION_WIDTH=10, FP_INT_WIDTH;
  - ceil_div function for stage sizing.
- The divider should migrate to fp_pkg as well.
- One combinational sub-module, fp_mul_stage:
  - inputs: accumulator, multiplicand, factor bit slice, bit offset;
  - output: the updated accumulator for BITS_PER_STAGE shift-add steps.
- fp_mul owns counter, handshake, rounding/saturation and the output register.

Test Plan:
- Basic product: factor 1536 (1.5), multiplicand 100, ROUND=1 → 150, err 0. valid_out appears exactly 7 cycles after the accept edge; busy clears 1 cycle later.
- Rounding: factor 512 (0.5), multiplicand 3 → 2 with ROUND=1 and 1 with ROUND=0. Factor 0, multiplicand 0xFFFFFFFF → 0, err 0.
- Overflow: factor 2048 (2.0), multiplicand 0x80000000 → product 0xFFFFFFFF, err_out 1 during valid_out. The next operation with in-range operands returns err 0.
- Divider round-trip: quotient 2389 (7/3 from the divider) times 3 → 7 with ROUND=1 and 6 with ROUND=0.
- Handshake: hold valid_in high for 20 cycles with changing operands → only the operands at edges k and k+8 are accepted. Exactly two valid_out pulses appear, with the matching products.
- Reset mid-operation: assert rst_in at the 4th busy cycle → busy=0 and product_out=0 next cycle, and no valid_out for 10 cycles. A fresh request then completes with the correct result.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared fixed-point definitions for the multiplier and divider.
// FP_WIDTH          : total bits of a fixed-point value.
// FP_FRACTION_WIDTH : fractional bits of a fixed-point value.
// FP_INT_WIDTH      : integer operand/result width.
// ceil_div          : rounding-up integer division used for stage sizing.
package fp_pkg;

  localparam int unsigned FP_WIDTH          = 42;
  localparam int unsigned FP_FRACTION_WIDTH = 10;
  localparam int unsigned FP_INT_WIDTH      = FP_WIDTH - FP_FRACTION_WIDTH;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/fp_mul_stage.sv
// One combinational shift-add slice of the sequential multiplier.
// acc_i    : running accumulator.
// mcand_i  : integer multiplicand.
// bits_i   : the factor bits handled by this slice, LSB first.
// offset_i : bit position of bits_i[0] within the factor.
// acc_o    : accumulator after adding mcand << (offset_i + i) for every set bits_i[i].
module fp_mul_stage
  import fp_pkg::*;
#(
  parameter int unsigned AccWidth     = FP_WIDTH + FP_INT_WIDTH,
  parameter int unsigned IntWidth     = FP_INT_WIDTH,
  parameter int unsigned BitsPerStage = 7,
  parameter int unsigned OffWidth     = 6
) (
  input  logic [AccWidth-1:0]     acc_i,
  input  logic [IntWidth-1:0]     mcand_i,
  input  logic [BitsPerStage-1:0] bits_i,
  input  logic [OffWidth-1:0]     offset_i,
  output logic [AccWidth-1:0]     acc_o
);

  always_comb begin
    acc_o = acc_i;
    for (int i = 0; i < int'(BitsPerStage); i++) begin
      if (bits_i[i]) begin
        acc_o = acc_o + (AccWidth'(mcand_i) << (int'(offset_i) + i));
      end
    end
  end

endmodule

// File: rtl/fp_mul.sv
// Sequential unsigned fixed-point x integer multiplier with rounding and saturation.
// Same handshake and latency as the fixed-point divider, so the two are interchangeable.
// clk_in          : clock.
// rst_in          : synchronous active-high reset.
// factor_in       : unsigned fixed-point factor (FRACTION_WIDTH fractional bits).
// multiplicand_in : unsigned integer multiplicand.
// valid_in        : request strobe, accepted when idle or in the result cycle.
// product_out     : saturated integer product, held until the next result.
// valid_out       : one-cycle result strobe.
// err_out         : overflow flag, qualified by valid_out.
// busy            : operation in flight (includes the result cycle).
// NUM_STAGES must be at least 3 and FRACTION_WIDTH at least 1.
module fp_mul
  import fp_pkg::*;
#(
  parameter int unsigned WIDTH          = FP_WIDTH,
  parameter int unsigned FRACTION_WIDTH = FP_FRACTION_WIDTH,
  parameter int unsigned NUM_STAGES     = 8,
  parameter bit          ROUND          = 1'b1
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic [WIDTH-1:0]                  factor_in,
  input  logic [WIDTH-FRACTION_WIDTH-1:0]   multiplicand_in,
  input  logic                              valid_in,
  output logic [WIDTH-FRACTION_WIDTH-1:0]   product_out,
  output logic                              valid_out,
  output logic                              err_out,
  output logic                              busy
);

  localparam int unsigned INT_WIDTH      = WIDTH - FRACTION_WIDTH;
  localparam int unsigned NUM_WORKING    = NUM_STAGES - 2;
  localparam int unsigned BITS_PER_STAGE = ceil_div(WIDTH, NUM_WORKING);
  localparam int unsigned PAD_WIDTH      = NUM_WORKING * BITS_PER_STAGE;
  localparam int unsigned ACC_WIDTH      = WIDTH + INT_WIDTH;
  localparam int unsigned CNT_WIDTH      = $clog2(NUM_STAGES + 1);
  localparam int unsigned OFF_WIDTH      = $clog2(PAD_WIDTH);
  localparam logic [ACC_WIDTH:0] ROUND_ADD =
      ROUND ? ((ACC_WIDTH + 1)'(1) << (FRACTION_WIDTH - 1)) : '0;

  logic [WIDTH-1:0]     factor_q, factor_d;
  logic [INT_WIDTH-1:0] mcand_q, mcand_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [INT_WIDTH-1:0] product_q, product_d;

  logic                      start;
  logic                      working;
  logic [CNT_WIDTH-1:0]      stage_idx;
  logic [OFF_WIDTH-1:0]      offset;
  logic [PAD_WIDTH-1:0]      factor_pad;
  logic [BITS_PER_STAGE-1:0] slice;
  logic [ACC_WIDTH-1:0]      acc_next;
  logic [ACC_WIDTH:0]        raw;
  logic [ACC_WIDTH:0]        res;
  logic                      overflow;

  // The result cycle (valid_q) doubles as the first free cycle, so back-to-back requests
  // are accepted every NUM_STAGES cycles while busy still reads high.
  assign start   = valid_in && (!busy_q || valid_q);
  // cnt_q = 1..NUM_WORKING are the shift-add cycles.
  assign working = (cnt_q != '0) && (cnt_q <= CNT_WIDTH'(NUM_WORKING));

  // Zero-padding the factor lets the last slice see only the remaining real bits.
  assign factor_pad = PAD_WIDTH'(factor_q);
  assign stage_idx  = working ? cnt_q - 1'b1 : '0;
  assign offset     = OFF_WIDTH'(32'(stage_idx) * BITS_PER_STAGE);
  assign slice      = factor_pad[offset +: BITS_PER_STAGE];

  fp_mul_stage #(
    .AccWidth     (ACC_WIDTH),
    .IntWidth     (INT_WIDTH),
    .BitsPerStage (BITS_PER_STAGE),
    .OffWidth     (OFF_WIDTH)
  ) u_stage (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .bits_i   (slice),
    .offset_i (offset),
    .acc_o    (acc_next)
  );

  // One spare bit keeps the rounding add from wrapping.
  assign raw      = {1'b0, acc_q} + ROUND_ADD;
  assign res      = raw >> FRACTION_WIDTH;
  assign overflow = |res[ACC_WIDTH:INT_WIDTH];

  always_comb begin
    factor_d  = factor_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    err_d     = err_q;
    product_d = product_q;

    if (busy_q) begin
      if (working) begin
        acc_d = acc_next;
        cnt_d = cnt_q + 1'b1;
      end else if (cnt_q == CNT_WIDTH'(NUM_STAGES - 1)) begin
        product_d = overflow ? '1 : res[INT_WIDTH-1:0];
        err_d     = overflow;
        valid_d   = 1'b1;
        cnt_d     = cnt_q + 1'b1;
      end else begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end

    if (start) begin
      factor_d = factor_in;
      mcand_d  = multiplicand_in;
      acc_d    = '0;
      cnt_d    = CNT_WIDTH'(1);
      busy_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      factor_q  <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      product_q <= '0;
    end else begin
      factor_q  <= factor_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      product_q <= product_d;
    end
  end

  assign product_out = product_q;
  assign valid_out   = valid_q;
  assign err_out     = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_fp_mul.sv
// Directed bench for fp_mul: a rounding instance and a truncating instance share stimulus.
module tb_fp_mul;
  import fp_pkg::*;

  localparam int unsigned W  = FP_WIDTH;
  localparam int unsigned IW = FP_INT_WIDTH;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [W-1:0]  factor_in;
  logic [IW-1:0] multiplicand_in;
  logic          valid_in;

  logic [IW-1:0] prod_r1, prod_r0;
  logic          vld_r1, vld_r0, err_r1, err_r0, busy_r1, busy_r0;

  int n_cmp = 0;
  int n_bad = 0;

  int            pulses;
  int            pulse_at [2];
  logic [IW-1:0] pulse_prod [2];

  always #5 clk_in = ~clk_in;

  fp_mul #(.NUM_STAGES(8), .ROUND(1'b1)) u_dut_r1 (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .factor_in       (factor_in),
    .multiplicand_in (multiplicand_in),
    .valid_in        (valid_in),
    .product_out     (prod_r1),
    .valid_out       (vld_r1),
    .err_out         (err_r1),
    .busy            (busy_r1)
  );

  fp_mul #(.NUM_STAGES(8), .ROUND(1'b0)) u_dut_r0 (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .factor_in       (factor_in),
    .multiplicand_in (multiplicand_in),
    .valid_in        (valid_in),
    .product_out     (prod_r0),
    .valid_out       (vld_r0),
    .err_out         (err_r0),
    .busy            (busy_r0)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request; checks latency, both instances' results, and the cycle after the strobe.
  task automatic run_op(input string tag, input logic [W-1:0] f, input logic [IW-1:0] m,
                        input logic [IW-1:0] exp_p1, input logic exp_e1,
                        input logic [IW-1:0] exp_p0, input logic exp_e0);
    int n;
    factor_in       = f;
    multiplicand_in = m;
    valid_in        = 1'b1;
    tick();
    valid_in = 1'b0;
    n = 0;
    while (!vld_r1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd7);
    check({tag, "_prod_r1"}, 64'(prod_r1), 64'(exp_p1));
    check({tag, "_err_r1"}, 64'(err_r1), 64'(exp_e1));
    check({tag, "_valid_r0"}, 64'(vld_r0), 64'd1);
    check({tag, "_prod_r0"}, 64'(prod_r0), 64'(exp_p0));
    check({tag, "_err_r0"}, 64'(err_r0), 64'(exp_e0));
    check({tag, "_busy_in_result"}, 64'(busy_r1), 64'd1);
    tick();
    check({tag, "_busy_after"}, 64'(busy_r1), 64'd0);
    check({tag, "_valid_after"}, 64'(vld_r1), 64'd0);
    check({tag, "_prod_held"}, 64'(prod_r1), 64'(exp_p1));
    check({tag, "_err_held"}, 64'(err_r1), 64'(exp_e1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_in          = 1'b1;
    valid_in        = 1'b0;
    factor_in       = '0;
    multiplicand_in = '0;
    tick();
    tick();
    check("rst_prod", 64'(prod_r1), 64'd0);
    check("rst_valid", 64'(vld_r1), 64'd0);
    check("rst_err", 64'(err_r1), 64'd0);
    check("rst_busy", 64'(busy_r1), 64'd0);

    // Reset wins over a simultaneous request.
    factor_in       = W'(1536);
    multiplicand_in = 32'd100;
    valid_in        = 1'b1;
    tick();
    check("rst_prio_busy", 64'(busy_r1), 64'd0);
    valid_in = 1'b0;
    rst_in   = 1'b0;
    tick();

    run_op("basic", W'(1536), 32'd100, 32'd150, 1'b0, 32'd150, 1'b0);
    run_op("half_of_3", W'(512), 32'd3, 32'd2, 1'b0, 32'd1, 1'b0);
    run_op("zero_factor", W'(0), 32'hFFFF_FFFF, 32'd0, 1'b0, 32'd0, 1'b0);
    run_op("zero_mcand", W'(1536), 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    run_op("overflow", W'(2048), 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
    run_op("after_ovf", W'(1024), 32'd12345, 32'd12345, 1'b0, 32'd12345, 1'b0);
    run_op("div_trip", W'(2389), 32'd3, 32'd7, 1'b0, 32'd6, 1'b0);
    // Max factor: rounding alone pushes the product past 32 bits.
    run_op("max_factor", {W{1'b1}}, 32'd1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0);
    run_op("top_bit", W'(1) << 41, 32'd1, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0);

    // Held request with changing multiplicand: edge k+j presents 10+j.
    pulses          = 0;
    factor_in       = W'(1536);
    multiplicand_in = 32'd10;
    valid_in        = 1'b1;
    for (int j = 0; j < 30; j++) begin
      tick();
      if (vld_r1) begin
        if (pulses < 2) begin
          pulse_at[pulses]   = j;
          pulse_prod[pulses] = prod_r1;
        end
        pulses++;
      end
      if (j < 15) multiplicand_in = IW'(11 + j);
      else        valid_in = 1'b0;
    end
    check("hs_pulses", 64'(pulses), 64'd2);
    check("hs_first_at", 64'(pulse_at[0]), 64'd7);
    check("hs_first_prod", 64'(pulse_prod[0]), 64'd15);
    check("hs_second_at", 64'(pulse_at[1]), 64'd15);
    check("hs_second_prod", 64'(pulse_prod[1]), 64'd27);
    check("hs_idle", 64'(busy_r1), 64'd0);

    // Abort in the 4th busy cycle.
    factor_in       = W'(1024);
    multiplicand_in = 32'd55;
    valid_in        = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
    tick();
    tick();
    check("abort_busy_before", 64'(busy_r1), 64'd1);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("abort_busy", 64'(busy_r1), 64'd0);
    check("abort_valid", 64'(vld_r1), 64'd0);
    check("abort_prod", 64'(prod_r1), 64'd0);
    pulses = 0;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (vld_r1 || vld_r0) pulses++;
    end
    check("abort_no_result", 64'(pulses), 64'd0);
    run_op("post_abort", W'(1024), 32'd55, 32'd55, 1'b0, 32'd55, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
